axis_sync_join: RTL and testbench

AXIS_SYNC_JOIN -- requirements
Module: axis_sync_join

---
 rtl/axis_sync_join_pkg.sv | 21 ++
 rtl/axis_pipeline_register2.sv | 84 ++++++++
 rtl/axis_sync_join.sv | 154 +++++++++++++++
 tb/tb_axis_sync_join.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_sync_join_pkg.sv
// Shared parameters and types for the weight/pixel stream join.
package axis_sync_join_pkg;

    localparam int COLS         = 4;
    localparam int ROWS         = 4;
    localparam int K_BITS       = 8;
    localparam int X_BITS       = 8;
    localparam int CONFIG_BEATS = 2;
    localparam int REG_SKID     = 2;

    typedef struct packed {
        logic       is_config;
        logic [2:0] tag;
    } tuser_st;

    typedef enum logic [0:0] {
        S_CFG  = 1'b0,
        S_DATA = 1'b1
    } state_e;

endpackage

// File: rtl/axis_pipeline_register2.sv
// AXI-stream register slice; REG_TYPE=2 gives a two-entry skid stage per LENGTH.
module axis_pipeline_register2 #(
    parameter int DATA_W   = 8,
    parameter int REG_TYPE = 2,
    parameter int LENGTH   = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o
);

    localparam int DEPTH = LENGTH * ((REG_TYPE == 2) ? 2 : 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_s;
    logic              pop_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // A full buffer still accepts when the head leaves in the same cycle.
    assign s_ready_o = (count_q < CNT_W'(DEPTH)) || m_ready_i;
    assign m_valid_o = (count_q != {CNT_W{1'b0}});
    assign m_data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy next state
    always_comb begin
        push_s   = s_valid_i && s_ready_o;
        pop_s    = m_valid_o && m_ready_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= s_data_i;
            end
        end
    end

endmodule

// File: rtl/axis_sync_join.sv
// Joins a weight stream (with interleaved config beats) and a pixel stream into one
// skid-buffered output stream, tracking config/data framing and flagging violations.
module axis_sync_join
    import axis_sync_join_pkg::*;
#(
    parameter int COLS         = axis_sync_join_pkg::COLS,
    parameter int ROWS         = axis_sync_join_pkg::ROWS,
    parameter int K_BITS       = axis_sync_join_pkg::K_BITS,
    parameter int X_BITS       = axis_sync_join_pkg::X_BITS,
    parameter int CONFIG_BEATS = axis_sync_join_pkg::CONFIG_BEATS
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_weights_tvalid,
    output logic                     s_weights_tready,
    input  logic                     s_weights_tlast,
    input  tuser_st                  s_weights_tuser,
    input  logic [COLS*K_BITS-1:0]   s_weights_tdata,
    input  logic                     s_pixels_tvalid,
    output logic                     s_pixels_tready,
    input  logic                     s_pixels_tlast,
    input  logic [ROWS*X_BITS-1:0]   s_pixels_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output tuser_st                  m_axis_tuser,
    output logic [COLS*K_BITS-1:0]   m_axis_tdata_w,
    output logic [ROWS*X_BITS-1:0]   m_axis_tdata_x,
    output logic                     err_protocol,
    output logic [31:0]              beats_joined
);

    localparam int W_W    = COLS * K_BITS;
    localparam int X_W    = ROWS * X_BITS;
    localparam int DATA_W = 1 + $bits(tuser_st) + W_W + X_W;
    localparam int CNT_W  = (CONFIG_BEATS > 1) ? $clog2(CONFIG_BEATS) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cfg_cnt_q, cfg_cnt_d;
    logic                err_q, err_d;
    logic [31:0]         beats_q, beats_d;
    logic                ready_en_q;
    logic                buf_ready_s;
    logic                is_cfg_s;
    logic                push_s;
    logic                cfg_acc_s;
    logic                data_acc_s;
    logic                viol_s;
    logic [X_W-1:0]      pix_x_s;
    logic [DATA_W-1:0]   buf_in_s;
    logic [DATA_W-1:0]   buf_out_s;

    // Handshake: config beats go alone, data beats need both streams at once
    always_comb begin
        is_cfg_s         = s_weights_tuser.is_config;
        s_weights_tready = ready_en_q && buf_ready_s && (is_cfg_s || s_pixels_tvalid);
        s_pixels_tready  = ready_en_q && buf_ready_s && !is_cfg_s && s_weights_tvalid;
        push_s           = s_weights_tvalid && s_weights_tready;
        cfg_acc_s        = push_s && is_cfg_s;
        data_acc_s       = push_s && !is_cfg_s;
        if (is_cfg_s) begin
            pix_x_s = {X_W{1'b0}};
        end else begin
            pix_x_s = s_pixels_tdata;
        end
        buf_in_s = {s_weights_tlast, s_weights_tuser, s_weights_tdata, pix_x_s};
    end

    axis_pipeline_register2 #(
        .DATA_W   (DATA_W),
        .REG_TYPE (REG_SKID),
        .LENGTH   (1)
    ) u_skid (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .s_valid_i (push_s),
        .s_ready_o (buf_ready_s),
        .s_data_i  (buf_in_s),
        .m_valid_o (m_axis_tvalid),
        .m_ready_i (m_axis_tready),
        .m_data_o  (buf_out_s)
    );

    assign {m_axis_tlast, m_axis_tuser, m_axis_tdata_w, m_axis_tdata_x} = buf_out_s;
    assign err_protocol = err_q;
    assign beats_joined = beats_q;

    // State, counters and the post-reset ready enable
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_CFG;
            cfg_cnt_q  <= {CNT_W{1'b0}};
            err_q      <= 1'b0;
            beats_q    <= 32'd0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_cnt_q  <= cfg_cnt_d;
            err_q      <= err_d;
            beats_q    <= beats_d;
            ready_en_q <= 1'b1;
        end
    end

    // Framing FSM; out-of-place beats leave state and counter untouched
    always_comb begin
        state_d   = state_q;
        cfg_cnt_d = cfg_cnt_q;
        case (state_q)
            S_CFG: begin
                if (cfg_acc_s) begin
                    if (cfg_cnt_q == CNT_W'(CONFIG_BEATS - 1)) begin
                        state_d   = S_DATA;
                        cfg_cnt_d = {CNT_W{1'b0}};
                    end else begin
                        cfg_cnt_d = cfg_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DATA: begin
                if (data_acc_s && s_weights_tlast) begin
                    state_d = S_CFG;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d   = S_CFG;
                cfg_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Violation detection, sticky error and joined-beat counter
    always_comb begin
        viol_s = 1'b0;
        if (cfg_acc_s && (state_q == S_DATA)) begin
            viol_s = 1'b1;
        end else if (data_acc_s && ((state_q == S_CFG) || (s_pixels_tlast && !s_weights_tlast))) begin
            viol_s = 1'b1;
        end else begin
            viol_s = 1'b0;
        end
        err_d = err_q || viol_s;
        if (data_acc_s) begin
            beats_d = beats_q + 32'd1;
        end else begin
            beats_d = beats_q;
        end
    end

endmodule

// File: tb/tb_axis_sync_join.sv
// Randomized bench for axis_sync_join with a queue-based reference model.
module tb_axis_sync_join;
    import axis_sync_join_pkg::*;

    localparam int W_W = COLS * K_BITS;
    localparam int X_W = ROWS * X_BITS;
    localparam int DW  = 1 + $bits(tuser_st) + W_W + X_W;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b1;
    logic            w_valid = 1'b0, w_last = 1'b0;
    tuser_st         w_user = '0;
    logic [W_W-1:0]  w_data = '0;
    logic            p_valid = 1'b0, p_last = 1'b0;
    logic [X_W-1:0]  p_data = '0;
    logic            m_ready = 1'b1;
    logic            s_weights_tready, s_pixels_tready;
    logic            m_axis_tvalid, m_axis_tlast, err_protocol;
    tuser_st         m_axis_tuser;
    logic [W_W-1:0]  m_axis_tdata_w;
    logic [X_W-1:0]  m_axis_tdata_x;
    logic [31:0]     beats_joined;
    logic [DW-1:0]   m_flat;

    axis_sync_join dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_weights_tvalid(w_valid), .s_weights_tready(s_weights_tready),
        .s_weights_tlast(w_last), .s_weights_tuser(w_user), .s_weights_tdata(w_data),
        .s_pixels_tvalid(p_valid), .s_pixels_tready(s_pixels_tready),
        .s_pixels_tlast(p_last), .s_pixels_tdata(p_data),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_ready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tdata_w(m_axis_tdata_w), .m_axis_tdata_x(m_axis_tdata_x),
        .err_protocol(err_protocol), .beats_joined(beats_joined)
    );

    always #5 aclk = ~aclk;
    assign m_flat = {m_axis_tlast, m_axis_tuser, m_axis_tdata_w, m_axis_tdata_x};

    typedef struct { logic last; tuser_st user; logic [W_W-1:0] data; } wbeat_t;
    typedef struct { logic last; logic [X_W-1:0] data; } pbeat_t;

    wbeat_t        wq[$];
    pbeat_t        pq[$];
    logic [DW-1:0] exp_q[$];
    int            push_cyc[$], pop_cyc[$];
    int            checks = 0, errors = 0, cyc_n = 0;
    bit            st_data_m = 1'b0, err_m = 1'b0, en_m = 1'b0, stall_m = 1'b0;
    int            cnt_m = 0;
    logic [31:0]   beats_m = 32'd0;
    logic [DW-1:0] prev_flat = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: capacity-2 queue plus framing rules, checked every cycle
    always @(negedge aclk) begin
        logic exp_wr, exp_pr, buf_ok, pop, push, cfg;
        cyc_n++;
        if (!aresetn) begin
            chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
            chk("rst_w_tready", s_weights_tready, 1'b0);
            chk("rst_p_tready", s_pixels_tready, 1'b0);
            chk("rst_err", err_protocol, 1'b0);
            chk("rst_beats", beats_joined, 32'd0);
            exp_q.delete();
            st_data_m = 1'b0; cnt_m = 0; err_m = 1'b0; beats_m = 32'd0;
            en_m = 1'b0; stall_m = 1'b0;
        end else begin
            cfg    = w_user.is_config;
            buf_ok = en_m && !(exp_q.size() >= 2 && !m_ready);
            exp_wr = buf_ok && (cfg || p_valid);
            exp_pr = buf_ok && !cfg && w_valid;
            chk("w_tready", s_weights_tready, exp_wr);
            chk("p_tready", s_pixels_tready, exp_pr);
            chk("m_tvalid", m_axis_tvalid, exp_q.size() > 0);
            if (exp_q.size() > 0) chk("m_beat", m_flat, exp_q[0]);
            if (stall_m) chk("m_stable", m_flat, prev_flat);
            chk("err", err_protocol, err_m);
            chk("beats", beats_joined, beats_m);
            stall_m   = m_axis_tvalid && !m_ready;
            prev_flat = m_flat;
            pop  = (exp_q.size() > 0) && m_ready;
            push = w_valid && exp_wr;
            if (pop) begin
                void'(exp_q.pop_front());
                pop_cyc.push_back(cyc_n);
            end
            if (push) begin
                exp_q.push_back({w_last, w_user, w_data, cfg ? {X_W{1'b0}} : p_data});
                push_cyc.push_back(cyc_n);
                if (cfg) begin
                    if (st_data_m) err_m = 1'b1;
                    else begin
                        cnt_m++;
                        if (cnt_m == CONFIG_BEATS) begin st_data_m = 1'b1; cnt_m = 0; end
                    end
                end else begin
                    beats_m = beats_m + 32'd1;
                    if (!st_data_m) err_m = 1'b1;
                    else if (w_last) st_data_m = 1'b0;
                    if (p_last && !w_last) err_m = 1'b1;
                end
            end
            en_m = 1'b1;
        end
    end

    task automatic add_frame(input int n_cfg, input int n_data, input int bad_idx);
        wbeat_t wb;
        pbeat_t pb;
        for (int i = 0; i < n_cfg; i++) begin
            wb.last = 1'($urandom_range(1, 0));
            wb.user.is_config = 1'b1;
            wb.user.tag = 3'($urandom);
            wb.data = W_W'($urandom);
            wq.push_back(wb);
        end
        for (int i = 0; i < n_data; i++) begin
            wb.last = (i == n_data - 1);
            wb.user.is_config = 1'b0;
            wb.user.tag = 3'($urandom);
            wb.data = W_W'($urandom);
            wq.push_back(wb);
            pb.last = (i == bad_idx) || wb.last;
            pb.data = X_W'($urandom);
            pq.push_back(pb);
        end
    endtask

    task automatic step(input int vpct, input int rpct);
        logic   w_hs, p_hs;
        wbeat_t wb;
        pbeat_t pb;
        @(negedge aclk);
        w_hs = w_valid && s_weights_tready;
        p_hs = p_valid && s_pixels_tready;
        @(posedge aclk);
        #1;
        if (w_hs) w_valid = 1'b0;
        if (p_hs) p_valid = 1'b0;
        if (!w_valid && wq.size() > 0 && $urandom_range(99, 0) < vpct) begin
            wb = wq.pop_front();
            w_valid = 1'b1; w_last = wb.last; w_user = wb.user; w_data = wb.data;
        end
        if (!p_valid && pq.size() > 0 && $urandom_range(99, 0) < vpct) begin
            pb = pq.pop_front();
            p_valid = 1'b1; p_last = pb.last; p_data = pb.data;
        end
        m_ready = ($urandom_range(99, 0) < rpct);
    endtask

    task automatic run(input int vpct, input int rpct, input int budget);
        int n = 0;
        while ((wq.size() > 0 || pq.size() > 0 || w_valid || p_valid || exp_q.size() > 0) && n < budget) begin
            step(vpct, rpct);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL run_timeout actual=%0d cycles required=<%0d", n, budget);
        end
        m_ready = 1'b1;
    endtask

    task automatic clr();
        push_cyc.delete();
        pop_cyc.delete();
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        wq.delete(); pq.delete();
        w_valid = 1'b0; p_valid = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        int bad, total_data, total_beats, n;
        #2 aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;

        // Config then 10 data beats at full rate
        clr();
        add_frame(2, 10, -1);
        run(100, 100, 200);
        chk("s1_pops", pop_cyc.size(), 12);
        bad = 0;
        for (int i = 0; i < 12 && i < push_cyc.size() && i < pop_cyc.size(); i++)
            if (pop_cyc[i] - push_cyc[i] != 1) bad++;
        chk("s1_latency_bad", bad, 0);
        if (pop_cyc.size() == 12) chk("s1_consecutive", pop_cyc[11] - pop_cyc[2], 9);
        chk("s1_beats", beats_joined, 32'd10);
        chk("s1_err", err_protocol, 1'b0);

        // FSM back in S_CFG: a new framed transfer raises no error
        clr();
        add_frame(2, 1, -1);
        run(100, 100, 100);
        chk("s1b_err", err_protocol, 1'b0);
        chk("s1b_beats", beats_joined, 32'd11);

        // Early pixel tlast on beat 3
        clr();
        add_frame(2, 10, 2);
        run(100, 100, 200);
        chk("s3_err", err_protocol, 1'b1);
        chk("s3_pops", pop_cyc.size(), 12);
        chk("s3_beats", beats_joined, 32'd21);

        // Data beat before config completes
        do_reset();
        clr();
        add_frame(1, 1, -1);
        run(100, 100, 100);
        chk("s2_err", err_protocol, 1'b1);
        chk("s2_pops", pop_cyc.size(), 2);
        repeat (3) step(100, 100);
        chk("s2_err_sticky", err_protocol, 1'b1);

        // Async reset with the buffer full
        do_reset();
        clr();
        add_frame(2, 6, -1);
        repeat (4) step(100, 100);
        repeat (4) step(100, 0);
        @(negedge aclk);
        chk("s4_full_tvalid", m_axis_tvalid, 1'b1);
        chk("s4_full_tready", s_weights_tready, 1'b0);
        chk("s4_beats_nonzero", beats_joined != 32'd0, 1'b1);
        @(posedge aclk);
        #1 aresetn = 1'b0;
        wq.delete(); pq.delete();
        w_valid = 1'b0; p_valid = 1'b0; m_ready = 1'b1;
        #1;
        chk("s4_async_tvalid", m_axis_tvalid, 1'b0);
        chk("s4_async_beats", beats_joined, 32'd0);
        chk("s4_async_tready", s_weights_tready, 1'b0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        clr();
        add_frame(2, 5, -1);
        run(70, 70, 500);
        chk("s4_fresh_err", err_protocol, 1'b0);
        chk("s4_fresh_beats", beats_joined, 32'd5);
        chk("s4_fresh_pops", pop_cyc.size(), 7);

        // Random gaps and backpressure over ~1000 data beats
        clr();
        total_data = 0;
        total_beats = 0;
        while (total_data < 1000) begin
            n = $urandom_range(8, 1);
            add_frame(CONFIG_BEATS, n, -1);
            total_data += n;
            total_beats += CONFIG_BEATS + n;
        end
        run(60, 50, 20000);
        chk("s5_pops", pop_cyc.size(), total_beats);
        chk("s5_beats", beats_joined, 32'(5 + total_data));
        chk("s5_err", err_protocol, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
